mc_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the RV32I datapath.
- Lets one shared memory port serve both instruction fetch and data access, with the datapath reusing a single ALU across cycles.
- Decodes op, funct3 and funct7b5, and drives per-state mux selects, write enables and ALU operation.
- Tolerates variable-latency memory via mem_ready, with a timeout that leads to a sticky fault.

---
 rtl/mc_control_fsm_if.sv | 44 ++++
 rtl/mc_control_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle for the multi-cycle sequencer; master = sequencer side, slave = datapath side.
// Debug step pins exist only when MC_STEP_DEBUG_EN is defined.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal;
  logic       bus_err;
`ifdef MC_STEP_DEBUG_EN
  logic       dbg_halt;
  logic       dbg_step;
  logic       dbg_halted;
`endif

  modport master (
`ifdef MC_STEP_DEBUG_EN
    input  dbg_halt, input dbg_step, output dbg_halted,
`endif
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, bus_err
  );

  modport slave (
`ifdef MC_STEP_DEBUG_EN
    output dbg_halt, output dbg_step, input dbg_halted,
`endif
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, bus_err
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencer; outputs decode combinationally from state, memory states stall on mem_ready
// with a MEM_TIMEOUT-cycle limit into a sticky fault. MC_STEP_DEBUG_EN adds halt/single-step of FETCH.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.master cif
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, FAULT
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       illegal_q, bus_err_q;
  logic       fetch_en, mem_wait, timeout_hit;

`ifdef MC_STEP_DEBUG_EN
  logic step_ok;
  assign fetch_en       = !cif.dbg_halt || step_ok;
  assign cif.dbg_halted = !rst && (state == FETCH) && !fetch_en;
`else
  assign fetch_en = 1'b1;
`endif

  assign mem_wait    = ((state == FETCH && fetch_en) || state == MEMREAD || state == MEMWRITE)
                       && !cif.mem_ready;
  assign timeout_hit = mem_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MC_STEP_DEBUG_EN
      step_ok   <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH:    if (fetch_en && cif.mem_ready) state <= DECODE;
        DECODE: begin
          case (cif.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_BR:        state <= BRANCH;
            OP_JAL:       state <= JAL;
            default: begin
              state     <= FAULT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEMADR:   state <= cif.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (cif.mem_ready) state <= MEMWB;
        MEMWRITE: if (cif.mem_ready) state <= FETCH;
        MEMWB, ALUWB, BRANCH:     state <= FETCH;
        EXECUTER, EXECUTEI, JAL:  state <= ALUWB;
        default:  state <= FAULT;
      endcase
      if (timeout_hit) begin
        state     <= FAULT;
        bus_err_q <= 1'b1;
      end
      wait_cnt <= (mem_wait && !timeout_hit) ? wait_cnt + 8'd1 : 8'd0;
`ifdef MC_STEP_DEBUG_EN
      // A step pulse arms one fetch; it is consumed when that fetch completes.
      if (state == FETCH && !fetch_en && cif.dbg_step) step_ok <= 1'b1;
      else if (state == FETCH && fetch_en && cif.mem_ready) step_ok <= 1'b0;
`endif
    end
  end

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7b5, input logic rtype);
    case (f3)
      3'b000:  return (rtype && f7b5) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0110;
      3'b010:  return 4'b0101;
      3'b011:  return 4'b1001;
      3'b100:  return 4'b0100;
      3'b101:  return f7b5 ? 4'b1000 : 4'b0111;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_ctl;

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctl    = 4'b0000;
    case (cif.op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
    case (state)
      FETCH: if (fetch_en) begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = cif.mem_ready;
        pc_write   = cif.mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_ctl   = alu_fn(cif.funct3, cif.funct7b5, 1'b1);
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctl   = alu_fn(cif.funct3, cif.funct7b5, 1'b0);
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctl   = 4'b0001;
        pc_write  = (cif.funct3 == 3'b000) ? cif.Zero :
                    (cif.funct3 == 3'b001) ? !cif.Zero : 1'b0;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cif.PCWrite    = !rst && pc_write;
  assign cif.AdrSrc     = !rst && adr_src;
  assign cif.MemWrite   = !rst && mem_write;
  assign cif.IRWrite    = !rst && ir_write;
  assign cif.RegWrite   = !rst && reg_write;
  assign cif.ResultSrc  = rst ? 2'b00 : result_src;
  assign cif.ALUSrcA    = rst ? 2'b00 : alu_src_a;
  assign cif.ALUSrcB    = rst ? 2'b00 : alu_src_b;
  assign cif.ImmSrc     = rst ? 2'b00 : imm_src;
  assign cif.ALUControl = rst ? 4'b0000 : alu_ctl;
  assign cif.illegal    = !rst && illegal_q;
  assign cif.bus_err    = !rst && bus_err_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: decode table, hand-written multi-cycle sequences, then random
// instruction streams checked against a per-instruction phase-sequence model.
module tb_mc_control_fsm;
  localparam int TO = 4;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int PH_F = 0, PH_D = 1, PH_A = 2, PH_R = 3, PH_MWB = 4, PH_W = 5,
                 PH_X = 6, PH_WB = 7, PH_B = 8, PH_J = 9;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  mc_control_fsm_if cif();
  mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .cif(cif));

  always #5 clk = ~clk;

`ifdef MC_STEP_DEBUG_EN
  initial begin
    cif.dbg_halt = 1'b0;
    cif.dbg_step = 1'b0;
  end
`endif

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, asa, asb, imm;
    logic [3:0] alu;
    logic       ill, berr;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       exec;
    logic [3:0] alu;
    logic [1:0] imm;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic outs_t dut_out();
    outs_t o;
    o = '{cif.PCWrite, cif.AdrSrc, cif.MemWrite, cif.IRWrite, cif.RegWrite, cif.ResultSrc,
          cif.ALUSrcA, cif.ALUSrcB, cif.ImmSrc, cif.ALUControl, cif.illegal, cif.bus_err};
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cif.op = OP_R; cif.funct3 = 3'b000; cif.funct7b5 = 1'b0;
    cif.Zero = 1'b0; cif.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_outputs_zero", 32'(dut_out()), 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- reference model: instruction = list of phases ----------------
  int  m_step, m_wait;
  bit  m_fault, m_ill, m_berr;

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
  endfunction

  function automatic int seq_len(input logic [6:0] op);
    case (op)
      OP_LW:   return 5;
      OP_BR:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_at(input logic [6:0] op, input int s);
    int p[5];
    case (op)
      OP_LW:       p = '{PH_F, PH_D, PH_A, PH_R, PH_MWB};
      OP_SW:       p = '{PH_F, PH_D, PH_A, PH_W, PH_F};
      OP_R, OP_I:  p = '{PH_F, PH_D, PH_X, PH_WB, PH_F};
      OP_BR:       p = '{PH_F, PH_D, PH_B, PH_F, PH_F};
      OP_JAL:      p = '{PH_F, PH_D, PH_J, PH_WB, PH_F};
      default:     p = '{PH_F, PH_D, PH_F, PH_F, PH_F};
    endcase
    return p[s];
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
    logic [3:0] t [8];
    t = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd8;
    return t[f3];
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == OP_SW) return 2'b01;
    if (op == OP_BR) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic outs_t m_out();
    outs_t e;
    int ph;
    e = '0;
    if (rst) return e;
    e.ill  = m_ill;
    e.berr = m_berr;
    e.imm  = imm_of(cif.op);
    if (m_fault) return e;
    ph = phase_at(cif.op, m_step);
    case (ph)
      PH_F:   begin e.asb = 2'b10; e.res = 2'b10; e.irw = cif.mem_ready; e.pcw = cif.mem_ready; end
      PH_D:   begin e.asa = 2'b01; e.asb = 2'b01; end
      PH_A:   begin e.asa = 2'b10; e.asb = 2'b01; end
      PH_R:   e.adr = 1'b1;
      PH_MWB: begin e.res = 2'b01; e.regw = 1'b1; end
      PH_W:   begin e.adr = 1'b1; e.memw = 1'b1; end
      PH_X:   begin
        e.asa = 2'b10;
        e.asb = (cif.op == OP_R) ? 2'b00 : 2'b01;
        e.alu = alu_of(cif.funct3, cif.funct7b5, cif.op == OP_R);
      end
      PH_WB:  e.regw = 1'b1;
      PH_B:   begin
        e.asa = 2'b10; e.alu = 4'b0001;
        e.pcw = (cif.funct3 == 3'd0) ? cif.Zero : (cif.funct3 == 3'd1) ? !cif.Zero : 1'b0;
      end
      PH_J:   begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic m_update();
    int ph;
    if (rst) begin
      m_step = 0; m_wait = 0; m_fault = 0; m_ill = 0; m_berr = 0;
      return;
    end
    if (m_fault) return;
    ph = phase_at(cif.op, m_step);
    if (ph == PH_F || ph == PH_R || ph == PH_W) begin
      if (cif.mem_ready) begin
        m_wait = 0;
        m_step++;
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_fault = 1; m_berr = 1; end
      end
    end else if (ph == PH_D && !legal(cif.op)) begin
      m_fault = 1; m_ill = 1;
    end else begin
      m_step++;
    end
    if (m_step >= seq_len(cif.op)) m_step = 0;
  endtask

  task automatic pick_instr();
    logic [6:0] ops [7];
    logic [6:0] bad [4];
    int k;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_R};
    bad = '{7'b1111111, 7'b0110111, 7'b1100111, 7'b0010111};
    k = $urandom_range(0, 15);
    cif.op       = (k == 15) ? bad[$urandom_range(0, 3)] : ops[k % 7];
    cif.funct3   = 3'($urandom_range(0, 7));
    cif.funct7b5 = 1'($urandom_range(0, 1));
  endtask

  task automatic run_branch(input string nm, input logic [2:0] f3, input logic z, input logic exp_pcw);
    do_reset();
    cif.op = OP_BR; cif.funct3 = f3; cif.Zero = z; cif.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk(nm, {cif.PCWrite, cif.ALUControl, cif.ALUSrcA, cif.ALUSrcB}, {exp_pcw, 4'b0001, 2'b10, 2'b00});
    @(negedge clk); #1;
    chk({nm, "_next_fetch"}, {cif.IRWrite, cif.illegal}, 2'b10);
  endtask

  vec_t vecs [17];
  int   cnt;
  bit   seen, ok;
  logic [3:0] strobes;
  int   fault_cycles;

  initial begin
    vecs[0]  = '{OP_R,   3'b000, 1'b0, 1'b1, 4'b0000, 2'b00};
    vecs[1]  = '{OP_R,   3'b000, 1'b1, 1'b1, 4'b0001, 2'b00};
    vecs[2]  = '{OP_R,   3'b101, 1'b1, 1'b1, 4'b1000, 2'b00};
    vecs[3]  = '{OP_R,   3'b101, 1'b0, 1'b1, 4'b0111, 2'b00};
    vecs[4]  = '{OP_R,   3'b011, 1'b0, 1'b1, 4'b1001, 2'b00};
    vecs[5]  = '{OP_R,   3'b100, 1'b0, 1'b1, 4'b0100, 2'b00};
    vecs[6]  = '{OP_R,   3'b110, 1'b0, 1'b1, 4'b0011, 2'b00};
    vecs[7]  = '{OP_R,   3'b111, 1'b0, 1'b1, 4'b0010, 2'b00};
    vecs[8]  = '{OP_R,   3'b010, 1'b0, 1'b1, 4'b0101, 2'b00};
    vecs[9]  = '{OP_I,   3'b000, 1'b1, 1'b1, 4'b0000, 2'b00};
    vecs[10] = '{OP_I,   3'b101, 1'b1, 1'b1, 4'b1000, 2'b00};
    vecs[11] = '{OP_I,   3'b001, 1'b0, 1'b1, 4'b0110, 2'b00};
    vecs[12] = '{OP_I,   3'b101, 1'b0, 1'b1, 4'b0111, 2'b00};
    vecs[13] = '{OP_SW,  3'b010, 1'b0, 1'b0, 4'b0000, 2'b01};
    vecs[14] = '{OP_BR,  3'b000, 1'b0, 1'b0, 4'b0000, 2'b10};
    vecs[15] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4'b0000, 2'b11};
    vecs[16] = '{OP_LW,  3'b010, 1'b0, 1'b0, 4'b0000, 2'b00};

    // add x3,x1,x2: FETCH, DECODE, EXECUTER, ALUWB, then FETCH again
    do_reset();
    cif.op = OP_R; cif.funct3 = 3'b000; cif.funct7b5 = 1'b0; cif.mem_ready = 1'b1; #1;
    chk("add_fetch", {cif.IRWrite, cif.PCWrite, cif.ALUSrcB, cif.ResultSrc, cif.RegWrite}, 7'b1_1_10_10_0);
    @(negedge clk); #1;
    chk("add_decode", {cif.ALUSrcA, cif.ALUSrcB, cif.RegWrite, cif.IRWrite}, 6'b01_01_0_0);
    @(negedge clk); #1;
    chk("add_execute", {cif.ALUSrcA, cif.ALUSrcB, cif.ALUControl, cif.RegWrite}, 9'b10_00_0000_0);
    @(negedge clk); #1;
    chk("add_aluwb", {cif.RegWrite, cif.ResultSrc, cif.PCWrite}, 4'b1_00_0);
    @(negedge clk); #1;
    chk("add_refetch", cif.IRWrite, 1'b1);

    // lw with three wait cycles in MEMREAD
    do_reset();
    cif.op = OP_LW; cif.funct3 = 3'b010;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cif.mem_ready = !(i >= 3 && i <= 5); #1;
      if (cif.AdrSrc) cnt++;
      if (i == 7) chk("lw_memwb", {cif.RegWrite, cif.ResultSrc}, 3'b1_01);
      @(negedge clk);
    end
    chk("lw_adrsrc_cycles", cnt, 4);
    cif.mem_ready = 1'b1; #1;
    chk("lw_total_8_cycles", cif.IRWrite, 1'b1);

    run_branch("beq_taken",     3'b000, 1'b1, 1'b1);
    run_branch("beq_not_taken", 3'b000, 1'b0, 1'b0);
    run_branch("bne_taken",     3'b001, 1'b0, 1'b1);
    run_branch("blt_ignored",   3'b100, 1'b0, 1'b0);

    // sw stuck on memory: MemWrite held for TO cycles, then sticky bus_err
    do_reset();
    cif.op = OP_SW; cif.funct3 = 3'b010;
    repeat (3) @(negedge clk);
    cif.mem_ready = 1'b0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cif.bus_err && !seen) begin
        seen = 1;
        chk("sw_fault_memwrite_low", cif.MemWrite, 1'b0);
      end
      if (cif.MemWrite) cnt++;
      @(negedge clk);
    end
    chk("sw_bus_err_seen", seen, 1'b1);
    chk("sw_memwrite_cycles", cnt, TO);
    cif.mem_ready = 1'b1; #1;
    chk("sw_fault_absorbing", {cif.bus_err, cif.illegal, cif.IRWrite}, 3'b100);
    do_reset();
    #1;
    chk("sw_rst_clears", {cif.bus_err, cif.IRWrite}, 2'b01);

    // unsupported opcode
    do_reset();
    cif.op = 7'b1111111; #1;
    @(negedge clk); #1;
    chk("ill_decode_not_yet", cif.illegal, 1'b0);
    @(negedge clk);
    strobes = '0; ok = 1;
    for (int i = 0; i < 6; i++) begin
      cif.Zero = 1'($urandom_range(0, 1));
      if (i == 2) cif.op = OP_R;
      #1;
      strobes |= {cif.RegWrite, cif.MemWrite, cif.PCWrite, cif.IRWrite};
      ok &= cif.illegal && !cif.bus_err;
      @(negedge clk);
    end
    chk("ill_no_strobes", strobes, 4'b0000);
    chk("ill_sticky", ok, 1'b1);

    // decode table
    for (int v = 0; v < 17; v++) begin
      do_reset();
      cif.op = vecs[v].op; cif.funct3 = vecs[v].f3; cif.funct7b5 = vecs[v].f7; #1;
      chk($sformatf("immsrc_vec%0d", v), cif.ImmSrc, vecs[v].imm);
      if (vecs[v].exec) begin
        @(negedge clk); @(negedge clk); #1;
        chk($sformatf("aluctl_vec%0d", v), cif.ALUControl, vecs[v].alu);
      end
    end

    // random instruction stream against the model
    do_reset();
    m_step = 0; m_wait = 0; m_fault = 0; m_ill = 0; m_berr = 0;
    fault_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_step == 0 && !m_fault) pick_instr();
      cif.Zero      = 1'($urandom_range(0, 1));
      cif.mem_ready = ($urandom_range(0, 3) != 0);
      rst = (m_fault && fault_cycles >= 2) || ($urandom_range(0, 199) == 0);
      #1;
      chk($sformatf("rand_cycle%0d", c), 32'(dut_out()), 32'(m_out()));
      m_update();
      fault_cycles = m_fault ? fault_cycles + 1 : 0;
      @(negedge clk);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
